serial_word_deser: RTL and testbench
====================================

SERIAL_WORD_DESER -- requirements
Module: serial_word_deser

Interface
REQ-001 Parameter WIDTH, default 7: data bits per frame, legal range 5..16.
REQ-002 Parameter LSB_FIRST, default 0: 0 = first data bit lands in out_data[WIDTH-1]; 1 = first data bit lands in out_data[0].
REQ-003 Parameter PARITY_EN, default 1: 1 = one parity bit follows the data bits; 0 = no parity bit.
REQ-004 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 Reset: rst is asynchronous and active-low; clock is clk.
REQ-006 clk  input  1  system clock; all state changes on the rising edge.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 in_bit  input  1  serial line value.
REQ-009 in_valid  input  1  in_bit is sampled only on edges where in_valid=1; other edges leave the frame state unchanged.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 out_data  output  WIDTH  last delivered word.
REQ-012 out_valid  output  1  out_data and parity_err hold an unconsumed word.
REQ-013 parity_err  output  1  parity mismatch on the word in out_data; 0 when PARITY_EN=0.
REQ-014 frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
REQ-015 overrun  output  1  one-cycle pulse: completed word dropped because the holding register was full.
REQ-016 ovr_cnt  output  8  saturating count of overrun events.
REQ-017 busy  output  1  1 whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, DATA, PAR and STOP, advancing only on edges with in_valid=1.
REQ-019 IDLE: in_bit=0 (start bit) goes to DATA with the bit counter cleared; in_bit=1 stays in IDLE.
REQ-020 DATA: each sample is shifted into the shift register per LSB_FIRST; after WIDTH samples the FSM goes to PAR if PARITY_EN=1, else to STOP.
REQ-021 PAR: the parity bit is sampled; a mismatch against the XOR of the data bits (inverted when PARITY_ODD=1) is stored in a pending-error flag; the FSM then goes to STOP.
REQ-022 STOP: in_bit=1 completes the frame and in_bit=0 pulses frame_err for one cycle and discards the word; either case returns to IDLE.
REQ-023 Frame completion with out_valid=0, or with out_valid=1 and out_ready=1 on the same edge, SHALL load out_data and parity_err and set out_valid=1 on that edge, i.e. zero cycles after the stop-bit sample.
REQ-024 Frame completion with out_valid=1 and out_ready=0 SHALL drop the new word, leave out_data and parity_err unchanged, pulse overrun, and increment ovr_cnt, which saturates at 255.
REQ-025 out_valid=1 and out_ready=1 with no completion on that edge SHALL clear out_valid on that edge; out_data keeps its value.
REQ-026 out_ready is ignored while out_valid=0.
REQ-027 frame_err and overrun are never both asserted for the same frame.
REQ-028 A frame_err frame SHALL NOT alter out_data, out_valid or parity_err.

Reset
REQ-029 While rst=0: state is IDLE, shift register and bit counter are 0, and out_data, out_valid, parity_err, frame_err, overrun, ovr_cnt and busy are 0.
REQ-030 Reset asserted mid-frame SHALL abandon the partial frame; after release, the first in_valid sample of 0 starts a new frame.

Verification (WIDTH=7; in_valid=1 every cycle unless stated)
REQ-031 Defaults; send frame 0,1,0,0,0,0,0,1,0,1 (start, 7'h41 MSB-first, even parity 0, stop) with out_ready=0 -> out_valid=1 on the stop edge, out_data=7'h41, parity_err=0; then out_ready=1 for one cycle -> out_valid=0.
REQ-032 The same frame with parity bit 1 -> out_data=7'h41, parity_err=1, frame_err=0.
REQ-033 The same frame with stop bit 0 -> one-cycle frame_err pulse, out_valid stays 0, busy=0 on the next cycle.
REQ-034 out_ready held 0; send 7'h41 then 7'h43 -> out_data stays 7'h41, overrun pulses once, ovr_cnt=1; then repeat with out_ready=1 on the stop edge -> out_data=7'h43, overrun=0.
REQ-035 LSB_FIRST=1, PARITY_EN=0: send 0,1,1,0,0,0,0,1,1 with in_valid=0 on alternate cycles -> out_data=7'h43.
REQ-036 Assert rst after 4 data bits -> all outputs 0; after release, a full 7'h41 frame is delivered correctly.

Source files
------------

// File: rtl/serial_word_deser_if.sv
// Handshake bundle for serial_word_deser: serial input side plus the word holding-register outputs.
interface serial_word_deser_if #(
  parameter int WIDTH = 7
);
  logic             in_bit;
  logic             in_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             parity_err;
  logic             frame_err;
  logic             overrun;
  logic [7:0]       ovr_cnt;
  logic             busy;

  modport master (
    output in_bit, in_valid, out_ready,
    input  out_data, out_valid, parity_err, frame_err, overrun, ovr_cnt, busy
  );

  modport slave (
    input  in_bit, in_valid, out_ready,
    output out_data, out_valid, parity_err, frame_err, overrun, ovr_cnt, busy
  );
endinterface

// File: rtl/serial_word_deser.sv
// Start/data/parity/stop serial deserialiser with a single-word holding register,
// frame-error and overrun pulses, and a saturating overrun counter.
module serial_word_deser #(
  parameter int WIDTH      = 7,
  parameter bit LSB_FIRST  = 1'b0,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic                clk,
  input logic                rst,
  serial_word_deser_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       ovr_cnt_q, ovr_cnt_d;
  logic             busy_q, busy_d;
  logic             complete;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    pend_d       = pend_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    ovr_cnt_d    = ovr_cnt_q;
    complete     = 1'b0;

    if (bus.in_valid) begin
      case (state_q)
        IDLE: begin
          if (!bus.in_bit) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            pend_d    = 1'b0;
          end
        end
        DATA: begin
          if (LSB_FIRST) shift_d = {bus.in_bit, shift_q[WIDTH-1:1]};
          else           shift_d = {shift_q[WIDTH-2:0], bus.in_bit};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(WIDTH - 1))
            state_d = PARITY_EN ? PAR : STOP;
        end
        PAR: begin
          // Mismatch when the received bit differs from the expected even/odd parity bit.
          pend_d  = bus.in_bit ^ (^shift_q) ^ PARITY_ODD;
          state_d = STOP;
        end
        STOP: begin
          if (bus.in_bit) complete    = 1'b1;
          else            frame_err_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // A consume and a completion on the same edge let the new word replace the old one.
    if (complete) begin
      if (!out_valid_q || bus.out_ready) begin
        out_data_d   = shift_q;
        parity_err_d = PARITY_EN & pend_q;
        out_valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
        if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      pend_q       <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      ovr_cnt_q    <= 8'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      pend_q       <= pend_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      ovr_cnt_q    <= ovr_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.ovr_cnt    = ovr_cnt_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_serial_word_deser.sv
// Directed bench: default MSB-first/even-parity instance plus an LSB-first, no-parity instance.
module tb_serial_word_deser;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  serial_word_deser_if #(.WIDTH(7)) bus_a ();
  serial_word_deser_if #(.WIDTH(7)) bus_b ();

  serial_word_deser #(.WIDTH(7)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  serial_word_deser #(.WIDTH(7), .LSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic drive_a(input logic b);
    @(negedge clk);
    bus_a.in_bit   = b;
    bus_a.in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic b, input logic v);
    @(negedge clk);
    bus_b.in_bit   = b;
    bus_b.in_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Start bit, MSB-first data and parity; the caller drives the stop bit.
  task automatic send_body_a(input logic [6:0] d, input logic p);
    drive_a(1'b0);
    for (int i = 6; i >= 0; i--) drive_a(d[i]);
    drive_a(p);
  endtask

  task automatic send_frame_a(input logic [6:0] d, input logic p, input logic s);
    send_body_a(d, p);
    drive_a(s);
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if (bus_a.out_valid !== 1'b0) begin
      $display("[TB] FAIL reset_out_valid: got %b expected 0", bus_a.out_valid); miscompares++;
    end
    vectors++;
    if (bus_a.out_data !== 7'h00) begin
      $display("[TB] FAIL reset_out_data: got %h expected 00", bus_a.out_data); miscompares++;
    end
    vectors++;
    if ({bus_a.parity_err, bus_a.frame_err, bus_a.overrun, bus_a.busy} !== 4'b0000) begin
      $display("[TB] FAIL reset_flags: got %b expected 0000",
               {bus_a.parity_err, bus_a.frame_err, bus_a.overrun, bus_a.busy}); miscompares++;
    end
    vectors++;
    if (bus_a.ovr_cnt !== 8'd0) begin
      $display("[TB] FAIL reset_ovr_cnt: got %0d expected 0", bus_a.ovr_cnt); miscompares++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic_frame;
    bus_a.out_ready = 1'b0;
    drive_a(1'b0);
    vectors++;
    if (bus_a.busy !== 1'b1) begin
      $display("[TB] FAIL busy_after_start: got %b expected 1", bus_a.busy); miscompares++;
    end
    for (int i = 6; i >= 0; i--) drive_a(7'h41 >> i);
    drive_a(1'b0);
    drive_a(1'b1);
    vectors++;
    if (bus_a.out_valid !== 1'b1) begin
      $display("[TB] FAIL basic_out_valid: got %b expected 1", bus_a.out_valid); miscompares++;
    end
    vectors++;
    if (bus_a.out_data !== 7'h41) begin
      $display("[TB] FAIL basic_out_data: got %h expected 41", bus_a.out_data); miscompares++;
    end
    vectors++;
    if (bus_a.parity_err !== 1'b0) begin
      $display("[TB] FAIL basic_parity_err: got %b expected 0", bus_a.parity_err); miscompares++;
    end
    vectors++;
    if (bus_a.busy !== 1'b0) begin
      $display("[TB] FAIL basic_busy_after_stop: got %b expected 0", bus_a.busy); miscompares++;
    end
    bus_a.out_ready = 1'b1;
    drive_a(1'b1);
    bus_a.out_ready = 1'b0;
    vectors++;
    if (bus_a.out_valid !== 1'b0) begin
      $display("[TB] FAIL basic_consume: got %b expected 0", bus_a.out_valid); miscompares++;
    end
    vectors++;
    if (bus_a.out_data !== 7'h41) begin
      $display("[TB] FAIL basic_data_kept: got %h expected 41", bus_a.out_data); miscompares++;
    end
  endtask

  task automatic test_parity_error;
    bus_a.out_ready = 1'b0;
    send_frame_a(7'h41, 1'b1, 1'b1);
    vectors++;
    if (bus_a.out_data !== 7'h41) begin
      $display("[TB] FAIL par_out_data: got %h expected 41", bus_a.out_data); miscompares++;
    end
    vectors++;
    if (bus_a.parity_err !== 1'b1) begin
      $display("[TB] FAIL par_parity_err: got %b expected 1", bus_a.parity_err); miscompares++;
    end
    vectors++;
    if (bus_a.frame_err !== 1'b0) begin
      $display("[TB] FAIL par_frame_err: got %b expected 0", bus_a.frame_err); miscompares++;
    end
    bus_a.out_ready = 1'b1;
    drive_a(1'b1);
    bus_a.out_ready = 1'b0;
    vectors++;
    if (bus_a.out_valid !== 1'b0) begin
      $display("[TB] FAIL par_consume: got %b expected 0", bus_a.out_valid); miscompares++;
    end
  endtask

  task automatic test_frame_error;
    send_frame_a(7'h41, 1'b0, 1'b0);
    vectors++;
    if (bus_a.frame_err !== 1'b1) begin
      $display("[TB] FAIL ferr_pulse: got %b expected 1", bus_a.frame_err); miscompares++;
    end
    vectors++;
    if (bus_a.out_valid !== 1'b0) begin
      $display("[TB] FAIL ferr_out_valid: got %b expected 0", bus_a.out_valid); miscompares++;
    end
    vectors++;
    if (bus_a.parity_err !== 1'b1) begin
      $display("[TB] FAIL ferr_parity_kept: got %b expected 1", bus_a.parity_err); miscompares++;
    end
    drive_a(1'b1);
    vectors++;
    if (bus_a.frame_err !== 1'b0) begin
      $display("[TB] FAIL ferr_one_cycle: got %b expected 0", bus_a.frame_err); miscompares++;
    end
    vectors++;
    if (bus_a.busy !== 1'b0) begin
      $display("[TB] FAIL ferr_busy: got %b expected 0", bus_a.busy); miscompares++;
    end
  endtask

  task automatic test_overrun;
    bus_a.out_ready = 1'b0;
    send_frame_a(7'h41, 1'b0, 1'b1);
    vectors++;
    if (bus_a.overrun !== 1'b0) begin
      $display("[TB] FAIL ovr_first_word: got %b expected 0", bus_a.overrun); miscompares++;
    end
    send_frame_a(7'h43, 1'b1, 1'b1);
    vectors++;
    if (bus_a.overrun !== 1'b1) begin
      $display("[TB] FAIL ovr_pulse: got %b expected 1", bus_a.overrun); miscompares++;
    end
    vectors++;
    if (bus_a.out_data !== 7'h41) begin
      $display("[TB] FAIL ovr_data_kept: got %h expected 41", bus_a.out_data); miscompares++;
    end
    vectors++;
    if (bus_a.ovr_cnt !== 8'd1) begin
      $display("[TB] FAIL ovr_cnt_one: got %0d expected 1", bus_a.ovr_cnt); miscompares++;
    end
    vectors++;
    if (bus_a.frame_err !== 1'b0) begin
      $display("[TB] FAIL ovr_no_frame_err: got %b expected 0", bus_a.frame_err); miscompares++;
    end
    drive_a(1'b1);
    vectors++;
    if (bus_a.overrun !== 1'b0) begin
      $display("[TB] FAIL ovr_one_cycle: got %b expected 0", bus_a.overrun); miscompares++;
    end
    send_body_a(7'h43, 1'b1);
    bus_a.out_ready = 1'b1;
    drive_a(1'b1);
    bus_a.out_ready = 1'b0;
    vectors++;
    if (bus_a.out_data !== 7'h43 || bus_a.out_valid !== 1'b1) begin
      $display("[TB] FAIL ovr_replace: got data %h valid %b expected 43 1",
               bus_a.out_data, bus_a.out_valid); miscompares++;
    end
    vectors++;
    if (bus_a.overrun !== 1'b0 || bus_a.ovr_cnt !== 8'd1) begin
      $display("[TB] FAIL ovr_replace_no_ovr: got ovr %b cnt %0d expected 0 1",
               bus_a.overrun, bus_a.ovr_cnt); miscompares++;
    end
  endtask

  task automatic test_ovr_saturation;
    bus_a.out_ready = 1'b0;
    for (int n = 0; n < 254; n++) send_frame_a(7'h43, 1'b1, 1'b1);
    vectors++;
    if (bus_a.ovr_cnt !== 8'd255) begin
      $display("[TB] FAIL sat_reach: got %0d expected 255", bus_a.ovr_cnt); miscompares++;
    end
    send_frame_a(7'h41, 1'b0, 1'b1);
    vectors++;
    if (bus_a.ovr_cnt !== 8'd255 || bus_a.overrun !== 1'b1) begin
      $display("[TB] FAIL sat_hold: got cnt %0d ovr %b expected 255 1",
               bus_a.ovr_cnt, bus_a.overrun); miscompares++;
    end
  endtask

  task automatic test_reset_mid_frame;
    drive_a(1'b0);
    for (int i = 6; i >= 3; i--) drive_a(7'h2A >> i);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== 7'h00) begin
      $display("[TB] FAIL rstmid_out: got valid %b data %h expected 0 00",
               bus_a.out_valid, bus_a.out_data); miscompares++;
    end
    vectors++;
    if (bus_a.ovr_cnt !== 8'd0 || bus_a.busy !== 1'b0) begin
      $display("[TB] FAIL rstmid_state: got cnt %0d busy %b expected 0 0",
               bus_a.ovr_cnt, bus_a.busy); miscompares++;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    send_frame_a(7'h41, 1'b0, 1'b1);
    vectors++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 7'h41 || bus_a.parity_err !== 1'b0) begin
      $display("[TB] FAIL rstmid_frame: got valid %b data %h perr %b expected 1 41 0",
               bus_a.out_valid, bus_a.out_data, bus_a.parity_err); miscompares++;
    end
    bus_a.in_valid = 1'b0;
  endtask

  task automatic test_lsb_first;
    logic [8:0] bits;
    bits = 9'b110000110;
    bus_b.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive_b(bits[i], 1'b1);
      drive_b(~bits[i], 1'b0);
    end
    vectors++;
    if (bus_b.out_valid !== 1'b1 || bus_b.out_data !== 7'h43) begin
      $display("[TB] FAIL lsb_word: got valid %b data %h expected 1 43",
               bus_b.out_valid, bus_b.out_data); miscompares++;
    end
    vectors++;
    if (bus_b.parity_err !== 1'b0 || bus_b.frame_err !== 1'b0) begin
      $display("[TB] FAIL lsb_flags: got perr %b ferr %b expected 0 0",
               bus_b.parity_err, bus_b.frame_err); miscompares++;
    end
  endtask

  initial begin
    bus_a.in_bit = 1'b1; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.in_bit = 1'b1; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0;
    test_reset;
    test_basic_frame;
    test_parity_error;
    test_frame_error;
    test_overrun;
    test_ovr_saturation;
    test_reset_mid_frame;
    test_lsb_first;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
